puf_soc_sipo: RTL and testbench

PUF_SOC_SIPO -- requirements
Module: puf_soc_sipo

---
 rtl/puf_soc_sipo.sv | 105 ++++++++++
 tb/tb_puf_soc_sipo.sv | 228 ++++++++++++++++++++++
 2 files changed

// File: rtl/puf_soc_sipo.sv
// Serial-in / parallel-out frame assembler for the PUF SoC link.
// Collects a normal- or debug-length frame LSB first and hands it off with a valid/ready pair.
module puf_soc_sipo #(
    parameter int FRAM_SIZE = 160,
    parameter int NORM_MOD  = 34,
    parameter int DEBUG_MOD = 133
) (
    input  logic                 clk,
    input  logic                 rst,
    input  logic                 i_rx_en,
    input  logic                 i_rx_mode,
    input  logic                 i_rx_valid,
    input  logic                 i_rx_data,
    output logic                 o_rx_ready,
    output logic [FRAM_SIZE-1:0] o_rx_data,
    output logic                 o_rx_valid,
    input  logic                 i_rx_ready,
    output logic                 o_rx_done
);

    // Handshakes: a transfer happens on a rising edge where valid and ready are both 1.
    // Serial side: i_rx_valid / o_rx_ready. Parallel side: o_rx_valid / i_rx_ready;
    // once o_rx_valid is high, o_rx_data is held until the transfer edge.

    localparam int CW = $clog2(DEBUG_MOD + 1);
    localparam logic [CW-1:0] NORM_LEN  = CW'(NORM_MOD);
    localparam logic [CW-1:0] DEBUG_LEN = CW'(DEBUG_MOD);
    localparam logic [CW-1:0] ONE       = CW'(1);

    if (NORM_MOD > FRAM_SIZE || DEBUG_MOD > FRAM_SIZE) begin : g_param_check
        $error("puf_soc_sipo: frame lengths must not exceed FRAM_SIZE");
    end

    typedef enum logic [1:0] {
        IDLE  = 2'd0,
        SHIFT = 2'd1,
        HOLD  = 2'd2
    } state_t;

    state_t               state;
    logic                 mode_q;
    logic [CW-1:0]        count;
    logic [FRAM_SIZE-1:0] shift_q;
    logic [FRAM_SIZE-1:0] shift_next;
    logic [CW-1:0]        frame_len;
    logic                 last_bit;

    assign o_rx_ready = (state == SHIFT);
    assign frame_len  = mode_q ? DEBUG_LEN : NORM_LEN;
    assign last_bit   = (count == frame_len - ONE);

    // Shift register is cleared at frame start, so bits above L stay zero.
    always_comb begin
        shift_next        = shift_q;
        shift_next[count] = i_rx_data;
    end

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            state      <= IDLE;
            mode_q     <= 1'b0;
            count      <= '0;
            shift_q    <= '0;
            o_rx_data  <= '0;
            o_rx_valid <= 1'b0;
            o_rx_done  <= 1'b0;
        end else begin
            o_rx_done <= 1'b0;
            case (state)
                IDLE: begin
                    if (i_rx_en) begin
                        mode_q  <= i_rx_mode;
                        count   <= '0;
                        shift_q <= '0;
                        state   <= SHIFT;
                    end
                end
                SHIFT: begin
                    if (!i_rx_en) begin
                        count   <= '0;
                        shift_q <= '0;
                        state   <= IDLE;
                    end else if (i_rx_valid) begin
                        shift_q <= shift_next;
                        count   <= count + ONE;
                        if (last_bit) begin
                            o_rx_data  <= shift_next;
                            o_rx_valid <= 1'b1;
                            state      <= HOLD;
                        end
                    end
                end
                HOLD: begin
                    if (i_rx_ready) begin
                        o_rx_valid <= 1'b0;
                        o_rx_done  <= 1'b1;
                        state      <= IDLE;
                    end
                end
                default: state <= IDLE;
            endcase
        end
    end

endmodule

// File: tb/tb_puf_soc_sipo.sv
// Randomized bench for puf_soc_sipo: frames are built as bit queues and compared
// against the parallel output through an expected-frame queue.
module tb_puf_soc_sipo;

    localparam int W = 160;

    logic         clk = 1'b0;
    logic         rst;
    logic         i_rx_en, i_rx_mode, i_rx_valid, i_rx_data, i_rx_ready;
    logic         o_rx_ready, o_rx_valid, o_rx_done;
    logic [W-1:0] o_rx_data;

    int           checks = 0;
    int           errors = 0;
    int           done_seen = 0;
    bit           hs_prev = 1'b0;
    logic [W-1:0] exp_q[$];
    logic [W-1:0] last_frame = '0;

    puf_soc_sipo dut (
        .clk        (clk),
        .rst        (rst),
        .i_rx_en    (i_rx_en),
        .i_rx_mode  (i_rx_mode),
        .i_rx_valid (i_rx_valid),
        .i_rx_data  (i_rx_data),
        .o_rx_ready (o_rx_ready),
        .o_rx_data  (o_rx_data),
        .o_rx_valid (o_rx_valid),
        .i_rx_ready (i_rx_ready),
        .o_rx_done  (o_rx_done)
    );

    // Clock and watchdog
    always #5 clk = ~clk;

    initial begin
        #3_000_000;
        $display("FAIL watchdog: got timeout required finish");
        $fatal(1, "watchdog expired");
    end

    task automatic check(input string tag, input logic [W-1:0] got, input logic [W-1:0] exp);
        checks++;
        if (got !== exp) begin
            errors++;
            $display("FAIL %s: got %h required %h", tag, got, exp);
        end
    endtask

    // Scoreboard: a parallel transfer is seen at the negedge before its edge;
    // o_rx_done must follow exactly one cycle later and at no other time.
    always @(negedge clk) begin
        check("done_pulse", W'(o_rx_done), W'(rst ? 1'b0 : hs_prev));
        if (o_rx_done) done_seen++;
        hs_prev = 1'b0;
        if (!rst && o_rx_valid && i_rx_ready) begin
            if (exp_q.size() == 0) check("spurious_frame", W'(1), W'(0));
            else check("frame_data", o_rx_data, exp_q.pop_front());
            hs_prev = 1'b1;
        end
    end

    // Driver tasks
    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    function automatic logic [W-1:0] rand_vec();
        logic [W-1:0] v;
        for (int k = 0; k < W / 32; k++) v[k*32 +: 32] = $urandom;
        return v;
    endfunction

    task automatic start_frame(input logic mode);
        i_rx_en    = 1'b1;
        i_rx_mode  = mode;
        i_rx_valid = 1'b0;
        tick();
        check("ready_in_shift", W'(o_rx_ready), W'(1));
    endtask

    task automatic send_bit(input logic b);
        i_rx_valid = 1'b1;
        i_rx_data  = b;
        tick();
        i_rx_valid = 1'b0;
    endtask

    task automatic send_frame(input logic mode, input logic [W-1:0] vec, input int gap_at,
                              input int gap_len, input int stall, input bit toggle,
                              input bit keep_en, input bit noise);
        int           len;
        logic [W-1:0] exp;
        bit           bits[$];
        len        = mode ? 133 : 34;
        i_rx_ready = 1'b0;
        start_frame(mode);
        for (int i = 0; i < len; i++) bits.push_back(vec[i]);
        exp = '0;
        for (int i = 0; i < len; i++) begin
            if (i == gap_at) begin
                repeat (gap_len) begin
                    tick();
                    check("ready_in_gap", W'(o_rx_ready), W'(1));
                end
            end
            if (noise && $urandom_range(0, 3) == 0) tick();
            if (toggle && i == 10) i_rx_mode = ~mode;
            exp = exp | (W'(bits[i]) << i);
            send_bit(bits[i]);
            if (i < len - 1 && (i == len - 2 || noise)) check("no_early_valid", W'(o_rx_valid), W'(0));
        end
        check("valid_latency", W'(o_rx_valid), W'(1));
        check("ready_low_hold", W'(o_rx_ready), W'(0));
        exp_q.push_back(exp);
        repeat (stall) begin
            if (noise) begin
                i_rx_en    = 1'($urandom_range(0, 1));
                i_rx_valid = 1'($urandom_range(0, 1));
                i_rx_data  = 1'($urandom_range(0, 1));
            end
            tick();
            check("hold_valid", W'(o_rx_valid), W'(1));
            check("hold_data", o_rx_data, exp);
        end
        i_rx_valid = 1'b0;
        i_rx_en    = keep_en;
        i_rx_ready = 1'b1;
        tick();
        i_rx_ready = 1'b0;
        check("valid_cleared", W'(o_rx_valid), W'(0));
        check("done_high", W'(o_rx_done), W'(1));
        check("data_retained", o_rx_data, exp);
        last_frame = exp;
        if (!keep_en) begin
            tick();
            check("idle_ready", W'(o_rx_ready), W'(0));
        end
    endtask

    initial begin
        logic [W-1:0] v;
        int           d0;
        rst = 1'b1; i_rx_en = 1'b0; i_rx_mode = 1'b0; i_rx_valid = 1'b0;
        i_rx_data = 1'b0; i_rx_ready = 1'b0;
        tick(); tick();
        check("rst_data", o_rx_data, '0);
        check("rst_ready", W'(o_rx_ready), W'(0));
        check("rst_valid", W'(o_rx_valid), W'(0));
        check("rst_done", W'(o_rx_done), W'(0));
        rst = 1'b0;
        tick();

        // Serial valid while idle is ignored
        i_rx_valid = 1'b1; i_rx_data = 1'b1;
        repeat (3) tick();
        i_rx_valid = 1'b0;
        check("idle_ready_low", W'(o_rx_ready), W'(0));
        check("idle_no_valid", W'(o_rx_valid), W'(0));

        // Directed normal frame
        v = W'(34'h2_1234_5678);
        send_frame(1'b0, v, -1, 0, 0, 1'b0, 1'b0, 1'b0);
        check("normal_frame_const", o_rx_data, W'(34'h2_1234_5678));

        // Debug frame with top bit set
        v = rand_vec();
        v[132] = 1'b1;
        send_frame(1'b1, v, -1, 0, 0, 1'b0, 1'b0, 1'b0);
        check("debug_upper_zero", W'(o_rx_data[W-1:133]), '0);

        // Serial gap after bit 10 plus downstream stall
        send_frame(1'b0, rand_vec(), 11, 5, 5, 1'b0, 1'b0, 1'b0);

        // Mode toggled mid normal frame
        send_frame(1'b0, rand_vec(), -1, 0, 2, 1'b1, 1'b0, 1'b0);

        // Abort after bit 20
        v = rand_vec();
        start_frame(1'b0);
        for (int i = 0; i <= 20; i++) send_bit(v[i]);
        i_rx_en = 1'b0;
        tick();
        check("abort_ready", W'(o_rx_ready), W'(0));
        repeat (40) tick();
        check("abort_no_valid", W'(o_rx_valid), W'(0));
        check("abort_keeps_data", o_rx_data, last_frame);
        send_frame(1'b0, rand_vec(), -1, 0, 1, 1'b0, 1'b0, 1'b0);

        // Reset mid frame
        v = rand_vec();
        start_frame(1'b1);
        for (int i = 0; i < 15; i++) send_bit(v[i]);
        rst = 1'b1;
        #1;
        check("midrst_data", o_rx_data, '0);
        check("midrst_ready", W'(o_rx_ready), W'(0));
        check("midrst_valid", W'(o_rx_valid), W'(0));
        i_rx_en = 1'b0;
        tick();
        rst = 1'b0;
        repeat (3) tick();
        check("midrst_no_valid", W'(o_rx_valid), W'(0));
        send_frame(1'b1, rand_vec(), -1, 0, 0, 1'b0, 1'b0, 1'b0);

        // Back-to-back frames with enable held
        d0 = done_seen;
        send_frame(1'b0, rand_vec(), -1, 0, 0, 1'b0, 1'b1, 1'b0);
        send_frame(1'b0, rand_vec(), -1, 0, 0, 1'b0, 1'b0, 1'b0);
        check("b2b_done_count", W'(done_seen - d0), W'(2));

        // Randomized frames: random mode, gaps, stalls and HOLD noise
        for (int n = 0; n < 8; n++) begin
            send_frame(1'($urandom_range(0, 1)), rand_vec(), $urandom_range(0, 33),
                       $urandom_range(0, 6), $urandom_range(0, 6), 1'($urandom_range(0, 1)),
                       1'($urandom_range(0, 1)), 1'b1);
        end
        i_rx_en = 1'b0;
        repeat (3) tick();
        check("queue_empty", W'(exp_q.size()), W'(0));

        $display("Result: errors=%0d of %0d checks", errors, checks);
        $finish;
    end

endmodule
